conv3x3_stream: RTL and testbench
=================================

# conv3x3_stream

Parametrised streaming 3x3 2-D convolution engine, the next generation of the fixed `conv` block that drives `image_out`. It accepts a raster-order pixel stream, holds two image rows in on-chip line buffers, and applies a run-time-loadable signed 3x3 kernel. Each output passes through an optional arithmetic shift, signed saturation and an optional ReLU. It sits between the pixel source (ROM or camera front end) and the downstream pooling/classification stages, with valid/ready handshakes on both sides.

## Interface
- DATA_W, 8, unsigned input pixel width
- COEF_W, 8, signed kernel coefficient width
- OUT_W, 16, signed output width
- IMG_W, 8, pixels per row (≥3)
- IMG_H, 8, rows per frame (≥3)
- SHIFT, 0, arithmetic right shift applied to the accumulator before saturation
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- coef_we  in  1  coefficient write strobe
- coef_addr  in  4  kernel index 0..8, row-major (0 = top-left, 4 = centre); 9..15 ignored
- coef_data  in  COEF_W  signed coefficient
- relu_en  in  1  1 = clamp negative results to 0; sampled per output
- in_valid  in  1  pixel_in is valid
- in_ready  out  1  engine accepts a pixel this cycle
- pixel_in  in  DATA_W  unsigned pixel, raster order
- out_valid  out  1  image_out holds a result
- out_ready  in  1  downstream accepts image_out
- image_out  out  OUT_W  signed convolution result
- frame_done  out  1  one-cycle pulse when the last result of a frame is accepted
- busy  out  1  a frame is in progress or a result is pending

## Operation
- A pixel is accepted when in_valid && in_ready; in_ready = !out_valid || out_ready, evaluated combinationally.
- col (0..IMG_W-1) and row (0..IMG_H-1) advance on each accepted pixel. col wraps to 0 and increments row. After pixel (IMG_H-1, IMG_W-1), both wrap to 0.
- Two line buffers of IMG_W entries each hold the previous two rows. A 3x3 window register shifts in the column {linebuf1, linebuf0, pixel_in} on every accept.
- A result is produced only for an accepted pixel with row ≥ 2 and col ≥ 2, giving (IMG_W-2)*(IMG_H-2) outputs per frame, 36 at the defaults. Window columns from the previous row never contaminate col 0/1 outputs.
- Arithmetic:
  - Each pixel is zero-extended to DATA_W+1 bits signed. Each product is DATA_W+COEF_W+1 bits signed.
  - The sum of 9 products is DATA_W+COEF_W+5 bits signed, so it never overflows.
  - The sum is arithmetic-right-shifted by SHIFT, saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1], then clamped to 0 if relu_en=1 and the result is negative.
- Coefficients: 9 registers, reset to 0. A write is applied only when busy=0; writes while busy=1 are dropped.
- busy = (row≠0 || col≠0 || out_valid).
- Line buffer contents are not reset. The window logic must not depend on their contents before rows 0/1 are written.

## Timing
- Reset (rst=0, asynchronous): in_ready=1, out_valid=0, image_out=0, frame_done=0, busy=0. col, row and all coefficients are cleared. A reset mid-frame discards the partial frame and any pending result. The first pixel after reset is (0,0).
- Latency: a result appears on image_out with out_valid=1 in the cycle after its completing pixel is accepted.
- Output handshake:
  - image_out and out_valid hold stable while out_valid && !out_ready.
  - If a result is accepted in the same cycle as a new window-completing pixel, out_valid stays 1 and image_out updates; there are no bubbles.
  - If a result is accepted with no new result, out_valid drops next cycle.
- Throughput: one pixel per cycle when out_ready=1.
- frame_done is asserted in the cycle after out_valid && out_ready for the result of pixel (IMG_H-1, IMG_W-1).
- Simultaneous coef_we and an accepted first pixel (busy=0): the write is applied. The first result is at least 2 rows later, so it sees the new value.

## Test plan
- Identity kernel (coef 4 = 1, others 0), SHIFT=0, ramp pixel = row*8+col, out_ready=1 -> 36 results in order 9,10,11,12,13,14,17,…,54; frame_done pulses once, after 54 is accepted.
- All coefficients 1, all pixels 255 -> 36 results of 2295. Repeat with SHIFT=3 -> 286.
- All coefficients -128, all pixels 255, relu_en=0 -> every result -32768 (saturated from -293760). Same with relu_en=1 -> every result 0.
- Identity ramp frame with out_ready held low for 10 cycles after the first out_valid -> in_ready=0 and image_out stable at 9 throughout; the full sequence afterwards is unchanged, with no loss or duplication.
- Write coef 4 = 5 at col=3 of row 1 mid-frame -> write ignored. Results match the prior kernel; coefficient readback through results of the next frame is also unchanged.
- Assert rst low for one cycle at row 4 mid-frame with a result pending -> outputs and busy go to 0 immediately. A following full identity frame yields exactly 36 correct results.

Source files
------------

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 signed-kernel convolution over a raster pixel stream.
// Two line buffers plus a two-column window feed one result per completing pixel.
module conv3x3_stream #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int OUT_W  = 16,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int SHIFT  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     coef_we,
  input  logic [3:0]               coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  input  logic                     relu_en,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        pixel_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  image_out,
  output logic                     frame_done,
  output logic                     busy
);

  localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int PROD_W = DATA_W + COEF_W + 1;
  localparam int ACC_W  = DATA_W + COEF_W + 5;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2**(OUT_W-1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2**(OUT_W-1)));

  logic [COL_W-1:0]         col;
  logic [ROW_W-1:0]         row;
  logic signed [COEF_W-1:0] coef [9];
  logic [DATA_W-1:0]        linebuf0 [IMG_W];
  logic [DATA_W-1:0]        linebuf1 [IMG_W];
  logic [DATA_W-1:0]        win [3][2];
  logic [DATA_W-1:0]        tap [3][3];
  logic                     accept;
  logic                     col_last;
  logic                     row_last;
  logic                     completes;
  logic                     out_last;
  logic signed [DATA_W:0]   px;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [OUT_W-1:0]  result;

  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign col_last  = (col == COL_W'(IMG_W - 1));
  assign row_last  = (row == ROW_W'(IMG_H - 1));
  assign completes = (row >= ROW_W'(2)) && (col >= COL_W'(2));
  assign busy      = (row != '0) || (col != '0) || out_valid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Kernel may only change between frames so a frame never mixes two kernels.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 9; i++) coef[i] <= '0;
    end else if (coef_we && !busy && (coef_addr < 4'd9)) begin
      coef[coef_addr] <= coef_data;
    end
  end

  // NOTE: line buffers and window are deliberately not reset; they are only
  // read at positions already written in the current frame, and leaving them
  // reset-free lets the buffers map onto plain RAM.
  always_ff @(posedge clk) begin
    if (accept) begin
      linebuf1[col] <= linebuf0[col];
      linebuf0[col] <= pixel_in;
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= tap[r][2];
      end
    end
  end

  // Rightmost window column is the live column, so the result is ready at accept.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      tap[r][0] = win[r][0];
      tap[r][1] = win[r][1];
    end
    tap[0][2] = linebuf1[col];
    tap[1][2] = linebuf0[col];
    tap[2][2] = pixel_in;
  end

  // NOTE: every always_comb output gets a value on every path (defaults
  // first) so no latch is inferred.
  always_comb begin
    acc  = '0;
    px   = '0;
    prod = '0;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) begin
        px   = signed'({1'b0, tap[r][k]});
        prod = PROD_W'(px) * PROD_W'(coef[r*3 + k]);
        acc  = acc + ACC_W'(prod);
      end
    end
    shifted = acc >>> SHIFT;
    if (shifted > SAT_MAX) begin
      result = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      result = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      result = shifted[OUT_W-1:0];
    end
    if (relu_en && result[OUT_W-1]) begin
      result = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      image_out  <= '0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= out_valid && out_ready && out_last;
      if (accept && completes) begin
        out_valid <= 1'b1;
        image_out <= result;
        out_last  <= row_last && col_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Self-checking bench for conv3x3_stream: a frame-level reference model
// predicts every result; SHIFT=0 and SHIFT=3 instances share the stimulus.
module tb_conv3x3_stream;

  localparam int W = 8;
  localparam int H = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic coef_we = 1'b0;
  logic [3:0] coef_addr = '0;
  logic signed [7:0] coef_data = '0;
  logic relu_en = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [7:0] pixel_in = '0;

  logic in_ready0, out_valid0, frame_done0, busy0;
  logic in_ready3, out_valid3, frame_done3, busy3;
  logic signed [15:0] image_out0, image_out3;

  always #5 clk = ~clk;

  conv3x3_stream #(.SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .relu_en(relu_en), .in_valid(in_valid),
    .in_ready(in_ready0), .pixel_in(pixel_in), .out_valid(out_valid0),
    .out_ready(out_ready), .image_out(image_out0), .frame_done(frame_done0),
    .busy(busy0)
  );

  conv3x3_stream #(.SHIFT(3)) dut3 (
    .clk(clk), .rst(rst), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .relu_en(relu_en), .in_valid(in_valid),
    .in_ready(in_ready3), .pixel_in(pixel_in), .out_valid(out_valid3),
    .out_ready(out_ready), .image_out(image_out3), .frame_done(frame_done3),
    .busy(busy3)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  typedef struct {
    int v0;
    int v3;
    bit last;
  } res_t;

  int   coef_m [9];
  int   img [H][W];
  int   mrow = 0;
  int   mcol = 0;
  res_t q[$];
  bit   fd_exp = 1'b0;
  bit   fd_next;
  bit   m_valid, m_ready, m_busy;

  // Per-frame observations for the literal checks
  int res_cnt = 0;
  int fd_cnt = 0;
  int first0 = 0, first3 = 0, last0 = 0;

  function automatic int ref_conv(int r0, int c0, int sh, bit relu);
    longint a = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        a += longint'(coef_m[i*3 + j]) * longint'(img[r0-2+i][c0-2+j]);
    a = a >>> sh;
    if (a > 32767) a = 32767;
    else if (a < -32768) a = -32768;
    if (relu && a < 0) a = 0;
    return int'(a);
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      check("rst_out_valid", out_valid0, 0);
      check("rst_out_valid3", out_valid3, 0);
      check("rst_image_out", image_out0, 0);
      check("rst_in_ready", in_ready0, 1);
      check("rst_busy", busy0, 0);
      check("rst_frame_done", frame_done0, 0);
      q.delete();
      mrow = 0;
      mcol = 0;
      fd_exp = 1'b0;
      for (int i = 0; i < 9; i++) coef_m[i] = 0;
    end else begin
      m_valid = (q.size() > 0);
      m_ready = !m_valid || out_ready;
      m_busy  = (mrow != 0) || (mcol != 0) || m_valid;
      check("out_valid", out_valid0, m_valid);
      check("out_valid3", out_valid3, m_valid);
      if (m_valid) begin
        check("image_out", image_out0, q[0].v0);
        check("image_out3", image_out3, q[0].v3);
      end
      check("in_ready", in_ready0, m_ready);
      check("busy", busy0, m_busy);
      check("busy3", busy3, m_busy);
      check("frame_done", frame_done0, fd_exp);
      check("frame_done3", frame_done3, fd_exp);
      if (frame_done0) fd_cnt++;

      fd_next = 1'b0;
      if (m_valid && out_ready) begin
        fd_next = q[0].last;
        res_cnt++;
        if (res_cnt == 1) begin
          first0 = image_out0;
          first3 = image_out3;
        end
        last0 = image_out0;
        void'(q.pop_front());
      end

      if (in_valid && m_ready) begin
        res_t e;
        img[mrow][mcol] = pixel_in;
        if (mrow >= 2 && mcol >= 2) begin
          e.v0 = ref_conv(mrow, mcol, 0, relu_en);
          e.v3 = ref_conv(mrow, mcol, 3, relu_en);
          e.last = (mrow == H-1) && (mcol == W-1);
          q.push_back(e);
        end
        mcol++;
        if (mcol == W) begin
          mcol = 0;
          mrow++;
          if (mrow == H) mrow = 0;
        end
      end

      if (coef_we && !m_busy && coef_addr < 9) coef_m[coef_addr] = coef_data;
      fd_exp = fd_next;
    end
  end

  // out_ready: 0 = always high, 1 = random, 2 = one 10-cycle stall after first out_valid
  int ready_mode = 0;
  int stall_left = 0;
  bit stall_used = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1: out_ready = ($urandom_range(99) < 60);
        2: begin
          if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
          end else if (!stall_used && out_valid0) begin
            stall_used = 1'b1;
            stall_left = 9;
            out_ready = 1'b0;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = 1'b1;
      endcase
    end
  end

  int src [H*W];
  int kern [9];

  task automatic set_src(input int mode);
    for (int i = 0; i < H*W; i++) begin
      case (mode)
        0: src[i] = (i / W) * 8 + (i % W);
        1: src[i] = 255;
        default: src[i] = int'($urandom_range(255));
      endcase
    end
  endtask

  task automatic load_kern();
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
      coef_we = 1'b1;
      coef_addr = 4'(i);
      coef_data = 8'(kern[i]);
    end
    @(posedge clk);
    #1;
    coef_we = 1'b0;
  endtask

  task automatic set_kern_all(input int v);
    for (int i = 0; i < 9; i++) kern[i] = v;
  endtask

  task automatic clear_stats();
    res_cnt = 0;
    fd_cnt = 0;
    first0 = 0;
    first3 = 0;
    last0 = 0;
  endtask

  // wr_idx: pixel index at which a coef 4 = 5 write is attempted (-1 none)
  // rst_idx: pixel index at which a one-cycle reset aborts the frame (-1 none)
  // wr_first: write coef 0 = wr_val together with the first pixel
  task automatic send_frame(input int gap_pct, input int wr_idx, input int rst_idx,
                            input bit wr_first, input int wr_val);
    int idx = 0;
    int cyc = 0;
    bit wr_done = 1'b0;
    while (idx < H*W && cyc < 3000) begin
      @(posedge clk);
      #1;
      coef_we = 1'b0;
      if (rst_idx >= 0 && idx == rst_idx) begin
        check("pending_before_rst", out_valid0, 1);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_now_out_valid", out_valid0, 0);
        check("rst_now_busy", busy0, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        return;
      end
      in_valid = ($urandom_range(99) >= gap_pct);
      pixel_in = 8'(src[idx]);
      if (!wr_done && idx == wr_idx) begin
        coef_we = 1'b1;
        coef_addr = 4'd4;
        coef_data = 8'sd5;
        wr_done = 1'b1;
      end
      if (!wr_done && wr_first && idx == 0) begin
        in_valid = 1'b1;
        coef_we = 1'b1;
        coef_addr = 4'd0;
        coef_data = 8'(wr_val);
        wr_done = 1'b1;
      end
      @(negedge clk);
      if (in_valid && in_ready0) idx++;
      cyc++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    coef_we = 1'b0;
    if (idx < H*W) check("frame_timeout", idx, H*W);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (q.size() > 0) check("drain_timeout", q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_identity(input string tag);
    check({tag, "_count"}, res_cnt, 36);
    check({tag, "_first"}, first0, 9);
    check({tag, "_last"}, last0, 54);
    check({tag, "_frame_done"}, fd_cnt, 1);
  endtask

  task automatic identity_kern();
    set_kern_all(0);
    kern[4] = 1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // Identity kernel over a ramp
    identity_kern();
    load_kern();
    set_src(0);
    clear_stats();
    send_frame(0, -1, -1, 1'b0, 0);
    drain();
    check_identity("ident");

    // All-ones kernel, flat 255 image
    set_kern_all(1);
    load_kern();
    set_src(1);
    clear_stats();
    send_frame(0, -1, -1, 1'b0, 0);
    drain();
    check("ones_count", res_cnt, 36);
    check("ones_first", first0, 2295);
    check("ones_first_shift3", first3, 286);

    // Saturation, then ReLU
    set_kern_all(-128);
    load_kern();
    clear_stats();
    send_frame(0, -1, -1, 1'b0, 0);
    drain();
    check("sat_first", first0, -32768);
    check("sat_last", last0, -32768);
    relu_en = 1'b1;
    clear_stats();
    send_frame(0, -1, -1, 1'b0, 0);
    drain();
    check("relu_first", first0, 0);
    check("relu_count", res_cnt, 36);
    relu_en = 1'b0;

    // Output back-pressure: 10-cycle stall on the first result
    identity_kern();
    load_kern();
    set_src(0);
    ready_mode = 2;
    stall_used = 1'b0;
    clear_stats();
    send_frame(0, -1, -1, 1'b0, 0);
    drain();
    check("stall_used", stall_used, 1);
    check_identity("stall");
    ready_mode = 0;

    // Coefficient write while busy is dropped, this frame and the next
    clear_stats();
    send_frame(0, 11, -1, 1'b0, 0);
    drain();
    check_identity("midwr");
    clear_stats();
    send_frame(0, -1, -1, 1'b0, 0);
    drain();
    check_identity("midwr_next");

    // Mid-frame reset with a result pending, then a clean identity frame
    send_frame(0, -1, 35, 1'b0, 0);
    repeat (2) @(posedge clk);
    #1;
    identity_kern();
    load_kern();
    clear_stats();
    send_frame(0, -1, -1, 1'b0, 0);
    drain();
    check_identity("postrst");

    // Randomised frames: random kernel, pixels, gaps, back-pressure, ReLU
    ready_mode = 1;
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 9; i++) kern[i] = int'($urandom_range(255)) - 128;
      load_kern();
      set_src(2);
      relu_en = $urandom_range(1);
      clear_stats();
      send_frame(30, -1, -1, 1'b1, int'($urandom_range(255)) - 128);
      drain();
      check("rand_count", res_cnt, 36);
      check("rand_frame_done", fd_cnt, 1);
    end
    ready_mode = 0;
    relu_en = 1'b0;
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
